// File: rtl/jpeg_dqt_pkg.sv
// Shared constants, zigzag-to-raster map and saturation helper for the JPEG dequantiser.
package jpeg_dqt_pkg;

  localparam int NUM_TABLES  = 4;
  localparam int TABLE_W     = 2;
  localparam int ZZ_W        = 6;
  localparam int TABLE_DEPTH = 64;
  localparam int RAM_AW      = TABLE_W + ZZ_W;
  localparam int Q_W         = 8;
  localparam int COEF_W      = 16;
  localparam int PROD_W      = 25;
  localparam int ID_W        = 32;

  localparam logic signed [PROD_W-1:0] SAT_MAX = 25'sd32767;
  localparam logic signed [PROD_W-1:0] SAT_MIN = -25'sd32768;

  // Zigzag scan position -> raster (row*8 + col) position within the 8x8 block.
  localparam logic [ZZ_W-1:0] ZIGZAG [TABLE_DEPTH] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Clamp a wide signed product into the signed 16-bit coefficient range.
  function automatic logic signed [COEF_W-1:0] saturate16(input logic signed [PROD_W-1:0] p);
    if (p > SAT_MAX) begin
      return 16'sh7fff;
    end else if (p < SAT_MIN) begin
      return 16'sh8000;
    end else begin
      return p[COEF_W-1:0];
    end
  endfunction

endpackage

// File: rtl/jpeg_dqt_ram.sv
// Quantisation table storage: 256 x 8 bits, one write port, one registered read port.
module jpeg_dqt_ram
  import jpeg_dqt_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [RAM_AW-1:0] waddr_i,
  input  logic [Q_W-1:0]    wdata_i,
  input  logic              re_i,
  input  logic [RAM_AW-1:0] raddr_i,
  output logic [Q_W-1:0]    rdata_o
);

  logic [Q_W-1:0] mem_q [NUM_TABLES*TABLE_DEPTH];
  logic [Q_W-1:0] rdata_q;
  logic [Q_W-1:0] rdata_d;

  // Read data only refreshes on a read request so it holds while the pipeline stalls.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  // Table contents are deliberately left unreset; writes and read register update here.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/jpeg_dqt.sv
// JPEG dequantiser: two-stage pipeline multiplying coefficients by table entries,
// saturating to 16 bits and converting zigzag positions to raster order.
module jpeg_dqt
  import jpeg_dqt_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     img_start_i,
  input  logic                     img_end_i,
  input  logic                     cfg_valid_i,
  input  logic [TABLE_W-1:0]       cfg_table_i,
  input  logic [ZZ_W-1:0]          cfg_idx_i,
  input  logic [Q_W-1:0]           cfg_data_i,
  output logic                     cfg_accept_o,
  input  logic                     inport_valid_i,
  input  logic signed [COEF_W-1:0] inport_data_i,
  input  logic [ZZ_W-1:0]          inport_idx_i,
  input  logic [TABLE_W-1:0]       inport_table_i,
  input  logic                     inport_eob_i,
  input  logic [ID_W-1:0]          inport_id_i,
  output logic                     inport_accept_o,
  output logic                     outport_valid_o,
  output logic signed [COEF_W-1:0] outport_data_o,
  output logic [ZZ_W-1:0]          outport_idx_o,
  output logic                     outport_eob_o,
  output logic [ID_W-1:0]          outport_id_o,
  input  logic                     outport_accept_i
);

  logic                     advance;
  logic                     cfg_write;
  logic                     in_fire;
  logic [Q_W-1:0]           q_rd;
  logic signed [PROD_W-1:0] product;
  logic                     img_end_unused;

  logic                     s1_valid_q, s1_valid_d;
  logic signed [COEF_W-1:0] s1_coef_q,  s1_coef_d;
  logic [ZZ_W-1:0]          s1_idx_q,   s1_idx_d;
  logic                     s1_eob_q,   s1_eob_d;
  logic [ID_W-1:0]          s1_id_q,    s1_id_d;

  logic                     s2_valid_q, s2_valid_d;
  logic signed [COEF_W-1:0] s2_data_q,  s2_data_d;
  logic [ZZ_W-1:0]          s2_idx_q,   s2_idx_d;
  logic                     s2_eob_q,   s2_eob_d;
  logic [ID_W-1:0]          s2_id_q,    s2_id_d;

  // End-of-image carries no behaviour; tables and pipeline ignore it.
  assign img_end_unused = img_end_i;

  // Table writes are only safe when no beat is waiting on a read.
  assign cfg_accept_o = !s1_valid_q && !s2_valid_q;

  // Handshake decode: cfg wins over data, and image start / reset refuse new beats.
  always_comb begin
    advance         = !s2_valid_q || outport_accept_i;
    cfg_write       = cfg_valid_i && cfg_accept_o;
    inport_accept_o = advance && !cfg_write && !img_start_i && !rst_i;
    in_fire         = inport_valid_i && inport_accept_o;
  end

  jpeg_dqt_ram u_ram (
    .clk_i   (clk_i),
    .we_i    (cfg_write),
    .waddr_i ({cfg_table_i, cfg_idx_i}),
    .wdata_i (cfg_data_i),
    .re_i    (in_fire),
    .raddr_i ({inport_table_i, inport_idx_i}),
    .rdata_o (q_rd)
  );

  // Stage 1 captures the beat alongside the table read issued in the same cycle.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_coef_d  = s1_coef_q;
    s1_idx_d   = s1_idx_q;
    s1_eob_d   = s1_eob_q;
    s1_id_d    = s1_id_q;
    if (advance) begin
      s1_valid_d = in_fire;
      if (in_fire) begin
        s1_coef_d = inport_data_i;
        s1_idx_d  = ZIGZAG[inport_idx_i];
        s1_eob_d  = inport_eob_i;
        s1_id_d   = inport_id_i;
      end
    end
    if (img_start_i) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 multiplies by the unsigned table value and saturates onto the output port.
  always_comb begin
    product    = $signed({{(PROD_W-COEF_W){s1_coef_q[COEF_W-1]}}, s1_coef_q})
               * $signed({{(PROD_W-Q_W){1'b0}}, q_rd});
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_idx_d   = s2_idx_q;
    s2_eob_d   = s2_eob_q;
    s2_id_d    = s2_id_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = saturate16(product);
        s2_idx_d  = s1_idx_q;
        s2_eob_d  = s1_eob_q;
        s2_id_d   = s1_id_q;
      end
    end
    if (img_start_i) begin
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset empties both stages and zeroes the visible outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_coef_q  <= '0;
      s1_idx_q   <= '0;
      s1_eob_q   <= 1'b0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_idx_q   <= '0;
      s2_eob_q   <= 1'b0;
      s2_id_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_coef_q  <= s1_coef_d;
      s1_idx_q   <= s1_idx_d;
      s1_eob_q   <= s1_eob_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_idx_q   <= s2_idx_d;
      s2_eob_q   <= s2_eob_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign outport_valid_o = s2_valid_q;
  assign outport_data_o  = s2_data_q;
  assign outport_idx_o   = s2_idx_q;
  assign outport_eob_o   = s2_eob_q;
  assign outport_id_o    = s2_id_q;

endmodule

// File: tb/tb_jpeg_dqt.sv
// Scoreboard bench for jpeg_dqt: a driver process issues cfg writes and beats and
// pushes model results; a monitor process pops and compares on each output handshake.
module tb_jpeg_dqt;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               img_start_i;
  logic               img_end_i;
  logic               cfg_valid_i;
  logic [1:0]         cfg_table_i;
  logic [5:0]         cfg_idx_i;
  logic [7:0]         cfg_data_i;
  logic               cfg_accept_o;
  logic               inport_valid_i;
  logic signed [15:0] inport_data_i;
  logic [5:0]         inport_idx_i;
  logic [1:0]         inport_table_i;
  logic               inport_eob_i;
  logic [31:0]        inport_id_i;
  logic               inport_accept_o;
  logic               outport_valid_o;
  logic signed [15:0] outport_data_o;
  logic [5:0]         outport_idx_o;
  logic               outport_eob_o;
  logic [31:0]        outport_id_o;
  logic               outport_accept_i;

  typedef struct {
    bit                 cfgEn;
    bit [1:0]           cfgTable;
    bit [5:0]           cfgIdx;
    bit [7:0]           cfgData;
    bit                 inEn;
    logic signed [15:0] coef;
    bit [5:0]           zz;
    bit [1:0]           tbl;
    bit                 eob;
    bit [31:0]          id;
  } stim_t;

  typedef struct {
    longint    data;
    int        idx;
    bit        eob;
    bit [31:0] id;
  } exp_t;

  stim_t stimQ[$];
  exp_t  expQ[$];
  int    modelTable [256];
  int    zzRaster [64];
  int    nCompared = 0;
  int    nMismatched = 0;
  int    cycleCount = 0;
  int    acceptMode = 0;
  int    idCounter = 1;
  bit    cfgBusy = 1'b0;
  bit    inBusy = 1'b0;
  int    lastCfgAcceptCycle = 0;
  int    lastInAcceptCycle = 0;
  int    lastValidRiseCycle = 0;
  bit    prevValid = 1'b0;

  jpeg_dqt dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .img_start_i      (img_start_i),
    .img_end_i        (img_end_i),
    .cfg_valid_i      (cfg_valid_i),
    .cfg_table_i      (cfg_table_i),
    .cfg_idx_i        (cfg_idx_i),
    .cfg_data_i       (cfg_data_i),
    .cfg_accept_o     (cfg_accept_o),
    .inport_valid_i   (inport_valid_i),
    .inport_data_i    (inport_data_i),
    .inport_idx_i     (inport_idx_i),
    .inport_table_i   (inport_table_i),
    .inport_eob_i     (inport_eob_i),
    .inport_id_i      (inport_id_i),
    .inport_accept_o  (inport_accept_o),
    .outport_valid_o  (outport_valid_o),
    .outport_data_o   (outport_data_o),
    .outport_idx_o    (outport_idx_o),
    .outport_eob_o    (outport_eob_o),
    .outport_id_o     (outport_id_o),
    .outport_accept_i (outport_accept_i)
  );

  // Free-running clock and cycle counter used for latency measurements.
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycleCount++;

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint satModel(input longint p);
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return p;
  endfunction

  task automatic applyStimulus(input int coef, input int zz, input int tbl, input bit eob);
    stim_t s;
    s = '{default: '0};
    s.inEn = 1'b1;
    s.coef = 16'(coef);
    s.zz   = 6'(zz);
    s.tbl  = 2'(tbl);
    s.eob  = eob;
    s.id   = idCounter;
    idCounter++;
    stimQ.push_back(s);
  endtask

  task automatic pushCfg(input int tbl, input int idx, input int data);
    stim_t s;
    s = '{default: '0};
    s.cfgEn    = 1'b1;
    s.cfgTable = 2'(tbl);
    s.cfgIdx   = 6'(idx);
    s.cfgData  = 8'(data);
    stimQ.push_back(s);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((stimQ.size() != 0 || cfgBusy || inBusy || expQ.size() != 0) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (stimQ.size() != 0 || cfgBusy || inBusy || expQ.size() != 0)
      checkOutput("idle_timeout", 1, 0);
  endtask

  task automatic waitDriverIdle(input int budget);
    int n = 0;
    while ((stimQ.size() != 0 || cfgBusy || inBusy) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (stimQ.size() != 0 || cfgBusy || inBusy)
      checkOutput("driver_timeout", 1, 0);
  endtask

  task automatic waitValid(input int budget);
    int n = 0;
    @(negedge clk_i);
    while (!outport_valid_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (!outport_valid_o)
      checkOutput("valid_timeout", 1, 0);
  endtask

  // Downstream backpressure: always ready, random, or held off.
  initial begin
    outport_accept_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (acceptMode)
        0:       outport_accept_i = 1'b1;
        1:       outport_accept_i = ($urandom_range(0, 3) != 0);
        default: outport_accept_i = 1'b0;
      endcase
    end
  end

  // Driver: presents one item at a time, updates the table model on cfg handshakes
  // and pushes the reference result on data handshakes.
  initial begin : driver
    stim_t cur;
    exp_t  e;
    cur            = '{default: '0};
    cfg_valid_i    = 1'b0;
    cfg_table_i    = '0;
    cfg_idx_i      = '0;
    cfg_data_i     = '0;
    inport_valid_i = 1'b0;
    inport_data_i  = '0;
    inport_idx_i   = '0;
    inport_table_i = '0;
    inport_eob_i   = 1'b0;
    inport_id_i    = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!cfgBusy && !inBusy && stimQ.size() > 0) begin
        cur            = stimQ.pop_front();
        cfgBusy        = cur.cfgEn;
        inBusy         = cur.inEn;
        cfg_table_i    = cur.cfgTable;
        cfg_idx_i      = cur.cfgIdx;
        cfg_data_i     = cur.cfgData;
        inport_data_i  = cur.coef;
        inport_idx_i   = cur.zz;
        inport_table_i = cur.tbl;
        inport_eob_i   = cur.eob;
        inport_id_i    = cur.id;
      end
      cfg_valid_i    = cfgBusy;
      inport_valid_i = inBusy;
      @(negedge clk_i);
      if (cfgBusy && cfg_accept_o) begin
        modelTable[int'(cur.cfgTable) * 64 + int'(cur.cfgIdx)] = int'(cur.cfgData);
        cfgBusy            = 1'b0;
        lastCfgAcceptCycle = cycleCount;
      end
      if (inBusy && inport_accept_o) begin
        e.data = satModel(longint'(cur.coef) *
                          longint'(modelTable[int'(cur.tbl) * 64 + int'(cur.zz)]));
        e.idx  = zzRaster[cur.zz];
        e.eob  = cur.eob;
        e.id   = cur.id;
        expQ.push_back(e);
        inBusy            = 1'b0;
        lastInAcceptCycle = cycleCount;
      end
    end
  end

  // Monitor: every output handshake must match the oldest outstanding expectation.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (!rst_i) begin
      if (outport_valid_o && !prevValid) lastValidRiseCycle = cycleCount;
      if (outport_valid_o && outport_accept_i) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_data", outport_data_o, e.data);
          checkOutput("out_idx", outport_idx_o, e.idx);
          checkOutput("out_eob", outport_eob_o, e.eob);
          checkOutput("out_id", outport_id_o, e.id);
        end
      end
    end
    prevValid = outport_valid_o;
  end

  // Test sequence: directed scenarios followed by randomized traffic.
  initial begin : main
    int pos;
    int r;
    pos = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int row = (s < 8 ? s : 7); row >= (s > 7 ? s - 7 : 0); row--) begin
          zzRaster[pos] = row * 8 + (s - row);
          pos = pos + 1;
        end
      end else begin
        for (int row = (s > 7 ? s - 7 : 0); row <= (s < 8 ? s : 7); row++) begin
          zzRaster[pos] = row * 8 + (s - row);
          pos = pos + 1;
        end
      end
    end

    rst_i       = 1'b1;
    img_start_i = 1'b0;
    img_end_i   = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    $display("[TB] reset state");
    checkOutput("rst_valid", outport_valid_o, 0);
    checkOutput("rst_data", outport_data_o, 0);
    checkOutput("rst_idx", outport_idx_o, 0);
    checkOutput("rst_eob", outport_eob_o, 0);
    checkOutput("rst_id", outport_id_o, 0);
    checkOutput("rst_cfg_accept", cfg_accept_o, 1);
    checkOutput("rst_in_accept", inport_accept_o, 1);

    for (int i = 0; i < 256; i++) pushCfg(i / 64, i % 64, $urandom_range(0, 255));
    waitIdle(2000);

    $display("[TB] unit table, latency");
    for (int i = 0; i < 64; i++) pushCfg(0, i, 1);
    waitIdle(500);
    applyStimulus(100, 2, 0, 1'b0);
    waitIdle(50);
    checkOutput("latency", lastValidRiseCycle - lastInAcceptCycle, 2);

    $display("[TB] saturation");
    pushCfg(1, 5, 255);
    pushCfg(1, 6, 2);
    applyStimulus(200, 5, 1, 1'b0);
    applyStimulus(-200, 5, 1, 1'b0);
    applyStimulus(-3, 6, 1, 1'b0);
    applyStimulus(32767, 5, 1, 1'b0);
    applyStimulus(-32768, 5, 1, 1'b1);
    applyStimulus(128, 5, 1, 1'b0);
    waitIdle(100);

    $display("[TB] cfg priority");
    begin
      stim_t s;
      s = '{default: '0};
      s.cfgEn = 1'b1; s.cfgTable = 2'd3; s.cfgIdx = 6'd10; s.cfgData = 8'd77;
      s.inEn = 1'b1; s.coef = 16'sd50; s.zz = 6'd10; s.tbl = 2'd3; s.id = idCounter;
      idCounter++;
      stimQ.push_back(s);
    end
    waitIdle(50);
    checkOutput("cfg_priority_gap", lastInAcceptCycle - lastCfgAcceptCycle, 1);

    $display("[TB] stall hold");
    acceptMode = 2;
    repeat (2) @(posedge clk_i);
    applyStimulus(-7, 0, 2, 1'b0);
    applyStimulus(9, 1, 2, 1'b0);
    applyStimulus(300, 2, 2, 1'b1);
    waitValid(20);
    repeat (5) begin
      @(negedge clk_i);
      checkOutput("hold_valid", outport_valid_o, 1);
      checkOutput("hold_data", outport_data_o, expQ[0].data);
      checkOutput("hold_idx", outport_idx_o, expQ[0].idx);
      checkOutput("hold_id", outport_id_o, expQ[0].id);
    end
    acceptMode = 0;
    waitIdle(50);

    $display("[TB] image start flush");
    acceptMode = 2;
    repeat (2) @(posedge clk_i);
    applyStimulus(11, 5, 1, 1'b0);
    applyStimulus(12, 6, 1, 1'b0);
    waitDriverIdle(20);
    @(posedge clk_i);
    #1 img_start_i = 1'b1;
    img_end_i = 1'b1;
    @(posedge clk_i);
    #1 img_start_i = 1'b0;
    img_end_i = 1'b0;
    expQ.delete();
    acceptMode = 0;
    repeat (5) begin
      @(negedge clk_i);
      checkOutput("no_valid_after_start", outport_valid_o, 0);
    end
    @(posedge clk_i);
    #1 img_start_i = 1'b1;
    @(negedge clk_i);
    checkOutput("start_blocks_accept", inport_accept_o, 0);
    @(posedge clk_i);
    #1 img_start_i = 1'b0;
    applyStimulus(100, 5, 1, 1'b0);
    applyStimulus(-3, 6, 1, 1'b1);
    applyStimulus(100, 2, 0, 1'b0);
    waitIdle(50);

    $display("[TB] reset mid stall");
    acceptMode = 2;
    repeat (2) @(posedge clk_i);
    applyStimulus(1234, 20, 2, 1'b0);
    applyStimulus(-999, 21, 3, 1'b1);
    waitDriverIdle(20);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    expQ.delete();
    @(negedge clk_i);
    checkOutput("rst2_valid", outport_valid_o, 0);
    checkOutput("rst2_data", outport_data_o, 0);
    checkOutput("rst2_idx", outport_idx_o, 0);
    checkOutput("rst2_eob", outport_eob_o, 0);
    checkOutput("rst2_id", outport_id_o, 0);
    checkOutput("rst2_cfg_accept", cfg_accept_o, 1);
    checkOutput("rst2_in_accept", inport_accept_o, 1);

    $display("[TB] random traffic");
    acceptMode = 1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        pushCfg($urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 255));
      end else if (r == 1) begin
        stimQ.push_back('{default: '0});
      end else begin
        applyStimulus(int'($signed(16'($urandom))), $urandom_range(0, 63),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end
    waitIdle(5000);
    acceptMode = 0;
    repeat (3) @(posedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/jpeg_dqt.md
JPEG_DQT -- requirements
Module: jpeg_dqt

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock; all logic rising-edge.
REQ-002 SHALL have ports: rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: img_start_i  in  1  start-of-image pulse; img_end_i  in  1  end-of-image pulse, informational only.
REQ-004 SHALL have ports: cfg_valid_i  in  1; cfg_table_i  in  2  table select; cfg_idx_i  in  6  zigzag position; cfg_data_i  in  8  quant value; cfg_accept_o  out  1.
REQ-005 SHALL have ports: inport_valid_i  in  1; inport_data_i  in  16  signed coefficient; inport_idx_i  in  6  zigzag position; inport_table_i  in  2; inport_eob_i  in  1; inport_id_i  in  32; inport_accept_o  out  1.
REQ-006 SHALL have ports: outport_valid_o  out  1; outport_data_o  out  16  signed dequantised coefficient; outport_idx_o  out  6  raster index; outport_eob_o  out  1; outport_id_o  out  32; outport_accept_i  in  1.
REQ-007 SHALL have parameter: none; all sizes fixed.

Function
REQ-008 SHALL hold 4 quantisation tables of 64 x 8-bit entries, addressed {table, zigzag idx}.
REQ-009 SHALL write a table entry when cfg_valid_i && cfg_accept_o.
REQ-010 SHALL drive cfg_accept_o high only when both pipeline stages are empty.
REQ-011 SHALL give cfg priority: a cycle with an accepted cfg write drives inport_accept_o low.
REQ-012 SHALL use a 2-stage pipeline: S1 registers the table read plus the coefficient, idx, eob and id fields; S2 registers the multiply and saturate result onto outport_*.
REQ-013 SHALL advance the pipeline when !outport_valid_o || outport_accept_i.
REQ-014 SHALL drive inport_accept_o = advance && !cfg write this cycle.
REQ-015 SHALL present output on cycle N+2 for an input accepted on cycle N when no stall occurs; throughput one per cycle.
REQ-016 SHALL compute product = signed16 coef x unsigned8 q as a 25-bit signed value.
REQ-017 SHALL saturate the product to [-32768, 32767].
REQ-018 SHALL map outport_idx_o = ZIGZAG[inport_idx_i] (standard JPEG zigzag-to-raster table; e.g. 0->0, 1->1, 2->8, 3->16, 4->9, 5->2, 63->63).
REQ-019 SHALL pass eob and id through unchanged, aligned with their coefficient.
REQ-020 SHALL hold all outport_* signals stable while outport_valid_o && !outport_accept_i.
REQ-021 SHALL lose or reorder no beat under any stall pattern.
REQ-022 SHALL, on img_start_i, clear both stage valids on the next edge; an input offered in the same cycle is not accepted.
REQ-023 SHALL retain table contents across img_start_i and img_end_i.
REQ-024 SHALL apply no range check to idx 63 without eob or to eob on any idx; pass them through as given.
REQ-025 SHALL return undefined data for reads of unwritten table entries; this is not a checked condition.

Reset
REQ-026 SHALL reset on rst_i: stage valids 0, outport_valid_o 0, outport_data_o 0, outport_idx_o 0, outport_eob_o 0, outport_id_o 0; cfg_accept_o 1 and inport_accept_o 1 in the first cycle after reset.
REQ-027 SHALL not reset the table RAM.
REQ-028 SHALL discard any in-flight beats when rst_i is asserted mid-block.

Structure
REQ-029 SHALL place the 64-entry ZIGZAG constant and the table-count and width constants in the shared jpeg package.
REQ-030 SHALL implement table storage as one sub-module, jpeg_dqt_ram: 256x8, registered read, single write port.

Verification
REQ-031 SHALL cover: table0 all 1s, coef 100 at zz 2, accept held 1 -> data 100, idx 8, valid exactly 2 cycles after accept.
REQ-032 SHALL cover: q=255, coef 200 -> 32767; coef -200 -> -32768; q=2, coef -3 -> -6.
REQ-033 SHALL cover: 3 beats (zz 0,1,2; eob on zz 2), outport_accept_i low for 5 cycles -> outputs held stable, then idx 0,1,8 delivered in order with eob on the last.
REQ-034 SHALL cover: pipeline empty, cfg_valid_i and inport_valid_i high together -> cfg written, inport_accept_o 0 that cycle, coefficient accepted next cycle using the new value.
REQ-035 SHALL cover: img_start_i pulsed with 2 beats in flight -> no outport_valid_o afterwards, and table values unchanged on the next block.
REQ-036 SHALL cover: rst_i asserted mid-stall -> all outputs 0 the next cycle, and the prior stall content never appears.
